// File: rtl/clock_adjust_fsm.sv
// rtl/clock_adjust_fsm.sv - time-adjust controller: NORM/ADJ states, field select, inactivity timeout.
// Optional hold-to-repeat adjust is enabled by defining CLKADJ_AUTOREPEAT_EN.
module clock_adjust_fsm #(
  parameter int NFIELD     = 3,
  parameter int TIMEOUT    = 30,
  parameter int REPEAT_DLY = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      TICK,
  input  logic                      SIG2HZ,
  input  logic                      MODE,
  input  logic                      SELECT,
  input  logic                      ADJUST,
  input  logic                      ADJUST_HOLD,
  output logic [NFIELD-1:0]         FIELDADJ,
  output logic [NFIELD-1:0]         FIELDON,
  output logic                      ADJMODE,
  output logic [$clog2(NFIELD)-1:0] SEL,
  output logic                      MODE24
);

  localparam int SELW = $clog2(NFIELD);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam logic [NFIELD-1:0] ONE_HOT0 = NFIELD'(1);

  typedef enum logic {NORM = 1'b0, ADJ = 1'b1} state_t;

  state_t            state, state_nx;
  logic [SELW-1:0]   sel, sel_nx, sel_eff;
  logic              mode24, mode24_nx;
  logic [NFIELD-1:0] fieldadj_nx;
  logic [7:0]        to_cnt, to_nx;
  logic              key_any;
  logic              rep_fire;

  // SEL values at or above NFIELD cannot occur, but decode them as field 0 anyway
  assign sel_eff = (int'(sel) < NFIELD) ? sel : '0;

`ifdef CLKADJ_AUTOREPEAT_EN
  localparam logic [7:0] RD_LIM = 8'(REPEAT_DLY);
  logic [7:0] hold_cnt, hold_nx;
  logic       hold_run;

  assign hold_run = (state == ADJ) && ADJUST_HOLD && !MODE && !SELECT;
  assign rep_fire = hold_run && TICK && (hold_cnt >= RD_LIM);
  assign key_any  = MODE | SELECT | ADJUST | ADJUST_HOLD;

  always_comb begin
    hold_nx = '0;
    if (hold_run) hold_nx = (TICK && hold_cnt != 8'hFF) ? hold_cnt + 8'd1 : hold_cnt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) hold_cnt <= '0;
    else      hold_cnt <= hold_nx;
  end
`else
  logic unused_hold;
  assign unused_hold = ADJUST_HOLD;
  assign rep_fire    = 1'b0;
  assign key_any     = MODE | SELECT | ADJUST;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= NORM;
      sel      <= '0;
      mode24   <= 1'b0;
      FIELDADJ <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      mode24   <= mode24_nx;
      FIELDADJ <= fieldadj_nx;
      to_cnt   <= to_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    sel_nx      = sel;
    mode24_nx   = mode24;
    fieldadj_nx = '0;
    to_nx       = '0;
    case (state)
      NORM: begin
        if (MODE) begin
          state_nx = ADJ;
          sel_nx   = '0;
        end else if (ADJUST) begin
          mode24_nx = ~mode24;
        end
      end
      ADJ: begin
        if (key_any)                      to_nx = '0;
        else if (TICK && to_cnt != 8'hFF) to_nx = to_cnt + 8'd1;
        else                              to_nx = to_cnt;
        if (MODE) begin
          state_nx = NORM;
        end else if (SELECT) begin
          sel_nx = (sel_eff == '0) ? SELW'(NFIELD - 1) : sel_eff - SELW'(1);
        end else if (ADJUST || rep_fire) begin
          fieldadj_nx = ONE_HOT0 << sel_eff;
        end else if (TIMEOUT != 0 && !key_any && to_cnt == TO_LIM) begin
          state_nx = NORM;
        end
      end
      default: state_nx = NORM;
    endcase
  end

  assign ADJMODE = (state == ADJ);
  assign SEL     = sel;
  assign MODE24  = mode24;

  always_comb begin
    FIELDON = '1;
    for (int i = 0; i < NFIELD; i++)
      if (ADJMODE && sel_eff == SELW'(i) && SIG2HZ) FIELDON[i] = 1'b0;
  end

endmodule

// File: tb/tb_clock_adjust_fsm.sv
// tb/tb_clock_adjust_fsm.sv - scoreboard bench for clock_adjust_fsm against a behavioural model.
module tb_clock_adjust_fsm;
  localparam int NF = 3;
  localparam int TO = 30;
  localparam int RD = 4;

  logic CLK = 0, RST = 0, TICK = 0, SIG2HZ = 0, MODE = 0, SELECT = 0, ADJUST = 0, ADJUST_HOLD = 0;
  logic [NF-1:0] FIELDADJ, FIELDON;
  logic ADJMODE, MODE24;
  logic [1:0] SEL;

  clock_adjust_fsm #(.NFIELD(NF), .TIMEOUT(TO), .REPEAT_DLY(RD)) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .SIG2HZ(SIG2HZ), .MODE(MODE), .SELECT(SELECT),
    .ADJUST(ADJUST), .ADJUST_HOLD(ADJUST_HOLD), .FIELDADJ(FIELDADJ), .FIELDON(FIELDON),
    .ADJMODE(ADJMODE), .SEL(SEL), .MODE24(MODE24));

  always #5 CLK = ~CLK;

  typedef struct {int due; int val;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, cyc = 0, pulses = 0;

  bit m_adj = 0, m_mode24 = 0;
  int m_sel = 0, m_idle = 0, m_hold = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: pops expected adjust pulses when they fall due, flags any unannounced pulse
  always begin
    @(posedge CLK); #2;
    if (FIELDADJ != 0) pulses++;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("fieldadj", int'(FIELDADJ), q[0].val);
      void'(q.pop_front());
    end else if (FIELDADJ != 0) begin
      n_cmp++; n_err++;
      $display("FAIL fieldadj_spurious: got %0d expected 0 (t=%0t)", FIELDADJ, $time);
    end
  end

  task automatic predict(input bit md, input bit sl, input bit ad, input bit hd, input bit tk);
    bit key, fire, expired;
    key = md | sl | ad;
    fire = 0;
`ifdef CLKADJ_AUTOREPEAT_EN
    key = key | hd;
    fire = m_adj && hd && tk && !md && !sl && (m_hold >= RD);
`endif
    if (!m_adj) begin
      m_hold = 0;
      if (md) begin m_adj = 1; m_sel = 0; m_idle = 0; end
      else if (ad) m_mode24 = !m_mode24;
    end else begin
      expired = (TO != 0) && (m_idle >= TO);
      if (md) m_adj = 0;
      else if (sl) m_sel = (m_sel + NF - 1) % NF;
      else if (ad || fire) q.push_back('{cyc + 1, 1 << m_sel});
      else if (expired) m_adj = 0;
      if (key) m_idle = 0;
      else if (tk && m_idle < 255) m_idle++;
      if (hd && !md && !sl) begin
        if (tk && m_hold < 255) m_hold++;
      end else m_hold = 0;
    end
  endtask

  task automatic check_state();
    int fo;
    fo = (1 << NF) - 1;
    if (m_adj && SIG2HZ) fo = fo & ~(1 << m_sel);
    chk("adjmode", int'(ADJMODE), int'(m_adj));
    chk("sel", int'(SEL), m_sel);
    chk("mode24", int'(MODE24), int'(m_mode24));
    chk("fieldon", int'(FIELDON), fo);
  endtask

  task automatic step(input bit md, input bit sl, input bit ad, input bit hd, input bit tk, input bit sg);
    MODE = md; SELECT = sl; ADJUST = ad; ADJUST_HOLD = hd; TICK = tk; SIG2HZ = sg;
    predict(md, sl, ad, hd, tk);
    @(negedge CLK);
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int p0, sel_tab[4], krate;
    bit hd;
    sel_tab = '{2, 1, 0, 2};
    repeat (2) @(negedge CLK);
    chk("reset_adjmode", int'(ADJMODE), 0);
    chk("reset_fieldadj", int'(FIELDADJ), 0);
    chk("reset_fieldon", int'(FIELDON), 7);
    RST = 1;
    idle(2);

    // field select walk and a single adjust pulse
    step(1, 0, 0, 0, 0, 0);
    chk("t2_sel0", int'(SEL), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("t2_selseq", int'(SEL), sel_tab[i]);
    end
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("t2_pulse", int'(FIELDADJ), 2);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_pulse_end", int'(FIELDADJ), 0);

    // MODE beats ADJUST; ADJUST in NORM toggles 12/24h
    step(1, 0, 1, 0, 0, 0);
    chk("t3_norm", int'(ADJMODE), 0);
    step(0, 0, 1, 0, 0, 0);
    chk("t3_m24_on", int'(MODE24), 1);
    step(0, 0, 1, 0, 0, 0);
    chk("t3_m24_off", int'(MODE24), 0);

    // timeout at the 30th tick, and a key near expiry restarting it
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0, 1, 0);
    idle(2);
    chk("t4_29_ticks", int'(ADJMODE), 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_expired", int'(ADJMODE), 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 2; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    chk("t4_key_clears", int'(ADJMODE), 1);

    // blink of the selected field only
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, i[0]);
      chk("t5_fieldon", int'(FIELDON), i[0] ? 3 : 7);
    end

    // hold-to-repeat at SEL=1
    step(0, 1, 0, 0, 0, 0);
    p0 = pulses;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);
    idle(4);
`ifdef CLKADJ_AUTOREPEAT_EN
    chk("t6_repeat_count", pulses - p0, 6);
`else
    chk("t6_repeat_count", pulses - p0, 0);
`endif

    // asynchronous reset mid-adjust with an ADJUST already presented
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("t1_pre_sel", int'(SEL), 2);
    ADJUST = 1;
    #1 RST = 0;
    #1;
    chk("t1_adjmode", int'(ADJMODE), 0);
    chk("t1_sel", int'(SEL), 0);
    chk("t1_mode24", int'(MODE24), 0);
    chk("t1_fieldon", int'(FIELDON), 7);
    chk("t1_fieldadj", int'(FIELDADJ), 0);
    @(negedge CLK);
    ADJUST = 0;
    @(negedge CLK);
    RST = 1;
    m_adj = 0; m_sel = 0; m_mode24 = 0; m_idle = 0; m_hold = 0;
    q.delete();
    idle(3);

    // randomized traffic alternating busy and quiet phases
    hd = 0;
    for (int i = 0; i < 4000; i++) begin
      krate = ((i / 300) % 2) ? 500 : 5;
      if ($urandom_range(0, 7) == 0) hd = !hd;
      step($urandom_range(0, krate - 1) == 0, $urandom_range(0, krate - 1) == 0,
           $urandom_range(0, krate - 1) == 0, hd, $urandom_range(0, 1) == 0,
           $urandom_range(0, 1) == 0);
    end
    idle(3);
    chk("pending_pulses", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
